// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-to-one memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // BUSY state that corresponds to a given owner.
  function automatic arb_state_t busy_state(input arb_owner_t own);
    return (own == OWN_D) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_req.sv
// Registered downstream request latch: loads the granted request, clears on release.
module mem_port_arbiter_req
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [width/8-1:0] req_byte_enable,
  input  logic [width-1:0]   req_address,
  input  logic [width-1:0]   req_wdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [width/8-1:0] mem_byte_enable,
  output logic [width-1:0]   mem_address,
  output logic [width-1:0]   mem_wdata
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else if (load) begin
      mem_read        <= req_read;
      mem_write       <= req_write;
      mem_byte_enable <= req_byte_enable;
      mem_address     <= req_address;
      mem_wdata       <= req_wdata;
    end else if (clear) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the LSQ.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [width/8-1:0] i_mem_byte_enable,
  input  logic [width-1:0]   i_mem_address,
  input  logic [width-1:0]   i_mem_wdata,
  output logic               i_mem_resp,
  output logic [width-1:0]   i_mem_rdata,
  input  logic               lsq_mem_read,
  input  logic               lsq_mem_write,
  input  logic [width/8-1:0] lsq_mem_byte_enable,
  input  logic [width-1:0]   lsq_mem_address,
  input  logic [width-1:0]   lsq_mem_wdata,
  output logic               lsq_mem_resp,
  output logic [width-1:0]   lsq_mem_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [width/8-1:0] mem_byte_enable,
  output logic [width-1:0]   mem_address,
  output logic [width-1:0]   mem_wdata,
  input  logic               mem_resp,
  input  logic [width-1:0]   mem_rdata,
  output logic               proto_err
);

  arb_state_t         state;
  arb_owner_t         last_grant;
  arb_owner_t         sel;
  logic               load;
  logic               clear;
  logic               i_valid;
  logic               d_valid;
  logic               i_bad;
  logic               d_bad;
  logic               sel_read;
  logic               sel_write;
  logic [width/8-1:0] sel_byte_enable;
  logic [width-1:0]   sel_address;
  logic [width-1:0]   sel_wdata;

  // A request with both strobes set is illegal and never counts as valid.
  assign i_bad   = i_mem_read & i_mem_write;
  assign d_bad   = lsq_mem_read & lsq_mem_write;
  assign i_valid = i_mem_read ^ i_mem_write;
  assign d_valid = lsq_mem_read ^ lsq_mem_write;

  // Grant decision; a completing owner only hands off to the other side.
  always_comb begin
    load  = 1'b0;
    clear = 1'b0;
    sel   = OWN_I;
    unique case (state)
      IDLE: begin
        if (i_valid && d_valid) begin
          load = 1'b1;
          sel  = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_valid) begin
          load = 1'b1;
          sel  = OWN_D;
        end else if (i_valid) begin
          load = 1'b1;
          sel  = OWN_I;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          if (d_valid) begin
            load = 1'b1;
            sel  = OWN_D;
          end else begin
            clear = 1'b1;
          end
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          if (i_valid) begin
            load = 1'b1;
            sel  = OWN_I;
          end else begin
            clear = 1'b1;
          end
        end
      end
      default: clear = 1'b1;
    endcase
  end

  assign sel_read        = (sel == OWN_D) ? lsq_mem_read        : i_mem_read;
  assign sel_write       = (sel == OWN_D) ? lsq_mem_write       : i_mem_write;
  assign sel_byte_enable = (sel == OWN_D) ? lsq_mem_byte_enable : i_mem_byte_enable;
  assign sel_address     = (sel == OWN_D) ? lsq_mem_address     : i_mem_address;
  assign sel_wdata       = (sel == OWN_D) ? lsq_mem_wdata       : i_mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= OWN_I;
      proto_err  <= 1'b0;
    end else begin
      if (load) begin
        state <= busy_state(sel);
      end else if (clear) begin
        state <= IDLE;
      end
      if (mem_resp && (state == BUSY_I)) begin
        last_grant <= OWN_I;
      end else if (mem_resp && (state == BUSY_D)) begin
        last_grant <= OWN_D;
      end
      if (i_bad || d_bad) begin
        proto_err <= 1'b1;
      end
    end
  end

  mem_port_arbiter_req #(
    .width(width)
  ) u_req (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .clear           (clear),
    .req_read        (sel_read),
    .req_write       (sel_write),
    .req_byte_enable (sel_byte_enable),
    .req_address     (sel_address),
    .req_wdata       (sel_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata)
  );

  // Response steering is combinational so the owner sees mem_resp in the same cycle.
  assign i_mem_resp    = mem_resp & (state == BUSY_I);
  assign lsq_mem_resp  = mem_resp & (state == BUSY_D);
  assign i_mem_rdata   = (state == BUSY_I) ? mem_rdata : '0;
  assign lsq_mem_rdata = (state == BUSY_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester models, a memory model and per-scenario tasks.
module tb_mem_port_arbiter;

  typedef struct {
    bit          own_d;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          chk_lat;
    bit          handoff;
    bit          idle_after;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [3:0]  i_mem_byte_enable = '0;
  logic [31:0] i_mem_address = '0, i_mem_wdata = '0;
  logic        i_mem_resp;
  logic [31:0] i_mem_rdata;
  logic        lsq_mem_read = 1'b0, lsq_mem_write = 1'b0;
  logic [3:0]  lsq_mem_byte_enable = '0;
  logic [31:0] lsq_mem_address = '0, lsq_mem_wdata = '0;
  logic        lsq_mem_resp;
  logic [31:0] lsq_mem_rdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  txn_t exp_q[$];
  txn_t req_i_q[$];
  txn_t req_d_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit mem_auto = 1'b1;
  bit spur_resp = 1'b0;
  int mem_lat = 2;
  int cnt = 0;
  logic [69:0] held;
  txn_t mt;
  txn_t ri, rd;
  int raise_cyc_i = 0, raise_cyc_d = 0;
  int last_resp_cyc = -100;
  bit pend_idle_chk = 1'b0;
  bit i_busy = 1'b0, d_busy = 1'b0, i_got = 1'b0, d_got = 1'b0, d_abort = 1'b0;
  int obs_i = 0, obs_d = 0;

  mem_port_arbiter #(.width(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_mem_read          (i_mem_read),
    .i_mem_write         (i_mem_write),
    .i_mem_byte_enable   (i_mem_byte_enable),
    .i_mem_address       (i_mem_address),
    .i_mem_wdata         (i_mem_wdata),
    .i_mem_resp          (i_mem_resp),
    .i_mem_rdata         (i_mem_rdata),
    .lsq_mem_read        (lsq_mem_read),
    .lsq_mem_write       (lsq_mem_write),
    .lsq_mem_byte_enable (lsq_mem_byte_enable),
    .lsq_mem_address     (lsq_mem_address),
    .lsq_mem_wdata       (lsq_mem_wdata),
    .lsq_mem_resp        (lsq_mem_resp),
    .lsq_mem_rdata       (lsq_mem_rdata),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_byte_enable     (mem_byte_enable),
    .mem_address         (mem_address),
    .mem_wdata           (mem_wdata),
    .mem_resp            (mem_resp),
    .mem_rdata           (mem_rdata),
    .proto_err           (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic txn_t mk(input bit own_d, input logic r, input logic w, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                              input bit chk_lat, input bit handoff, input bit idle_after);
    txn_t t;
    t.own_d = own_d; t.rd = r; t.wr = w; t.be = be; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.chk_lat = chk_lat; t.handoff = handoff; t.idle_after = idle_after;
    return t;
  endfunction

  // Observed response pulses, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (i_mem_resp === 1'b1) obs_i++;
    if (lsq_mem_resp === 1'b1) obs_d++;
  end

  // Fetch requester: holds a request until its response, drops it the next cycle.
  always @(negedge clk) begin : req_i_model
    if (!rst) begin
      i_mem_read = 1'b0; i_mem_write = 1'b0; i_busy = 1'b0; i_got = 1'b0;
    end else if (i_busy) begin
      if (i_got) begin
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_busy = 1'b0; i_got = 1'b0;
      end
    end else if (req_i_q.size() > 0) begin
      ri = req_i_q.pop_front();
      i_mem_read = ri.rd; i_mem_write = ri.wr; i_mem_byte_enable = ri.be;
      i_mem_address = ri.addr; i_mem_wdata = ri.wdata;
      i_busy = 1'b1; raise_cyc_i = cyc;
    end
  end

  // LSQ requester; d_abort withdraws a request that will never be answered.
  always @(negedge clk) begin : req_d_model
    if (!rst || d_abort) begin
      lsq_mem_read = 1'b0; lsq_mem_write = 1'b0; d_busy = 1'b0; d_got = 1'b0; d_abort = 1'b0;
    end else if (d_busy) begin
      if (d_got) begin
        lsq_mem_read = 1'b0; lsq_mem_write = 1'b0; d_busy = 1'b0; d_got = 1'b0;
      end
    end else if (req_d_q.size() > 0) begin
      rd = req_d_q.pop_front();
      lsq_mem_read = rd.rd; lsq_mem_write = rd.wr; lsq_mem_byte_enable = rd.be;
      lsq_mem_address = rd.addr; lsq_mem_wdata = rd.wdata;
      d_busy = 1'b1; raise_cyc_d = cyc;
    end
  end

  // Memory model and scoreboard: compares each grant with the expected queue head.
  always @(negedge clk) begin : mem_model
    if (!rst) begin
      cnt = 0; mem_resp = 1'b0; mem_rdata = '0; pend_idle_chk = 1'b0;
    end else if (!mem_auto) begin
      cnt = 0;
      mem_resp = spur_resp;
      mem_rdata = spur_resp ? 32'hBAD0_BAD0 : 32'h0;
    end else begin
      if (mem_resp) begin
        mem_resp = 1'b0; mem_rdata = '0; cnt = 0;
        if (pend_idle_chk) begin
          tests_run++;
          if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_resp: mem_read=%b mem_write=%b, required 0 0", mem_read, mem_write);
          end
          pend_idle_chk = 1'b0;
        end
      end
      if (mem_read || mem_write) begin
        cnt++;
        if (cnt == 1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_grant: addr=%h rd=%b wr=%b, required no grant", mem_address, mem_read, mem_write);
          end else begin
            mt = exp_q[0];
            if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !==
                {mt.rd, mt.wr, mt.be, mt.addr, mt.wdata}) begin
              tests_failed++;
              $display("FAIL grant_fields: rd=%b wr=%b be=%h addr=%h wdata=%h, required rd=%b wr=%b be=%h addr=%h wdata=%h (owner %s)",
                       mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
                       mt.rd, mt.wr, mt.be, mt.addr, mt.wdata, mt.own_d ? "D" : "I");
            end
            if (mt.handoff) begin
              tests_run++;
              if (cyc !== last_resp_cyc + 1) begin
                tests_failed++;
                $display("FAIL handoff_gap: grant cycle %0d, required %0d", cyc, last_resp_cyc + 1);
              end
            end
            if (mt.chk_lat) begin
              tests_run++;
              if (cyc !== (mt.own_d ? raise_cyc_d : raise_cyc_i) + 1) begin
                tests_failed++;
                $display("FAIL grant_latency: grant cycle %0d, required %0d", cyc,
                         (mt.own_d ? raise_cyc_d : raise_cyc_i) + 1);
              end
            end
          end
          held = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata};
        end else begin
          tests_run++;
          if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !== held) begin
            tests_failed++;
            $display("FAIL busy_stable: request %h, required %h", {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata}, held);
          end
        end
        if (cnt >= mem_lat && exp_q.size() > 0) begin
          mt = exp_q.pop_front();
          mem_rdata = mt.rdata;
          mem_resp = 1'b1;
          #1;
          tests_run++;
          if (i_mem_resp !== !mt.own_d || lsq_mem_resp !== mt.own_d ||
              (mt.own_d ? lsq_mem_rdata : i_mem_rdata) !== mt.rdata ||
              (mt.own_d ? i_mem_rdata : lsq_mem_rdata) !== 32'h0) begin
            tests_failed++;
            $display("FAIL resp_routing: i_resp=%b lsq_resp=%b i_rdata=%h lsq_rdata=%h, required owner %s rdata %h other 0",
                     i_mem_resp, lsq_mem_resp, i_mem_rdata, lsq_mem_rdata, mt.own_d ? "D" : "I", mt.rdata);
          end
          if (mt.own_d) d_got = 1'b1; else i_got = 1'b1;
          last_resp_cyc = cyc;
          pend_idle_chk = mt.idle_after;
        end
      end
    end
  end

  task automatic wait_quiet(input int budget, input bit inc_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && req_i_q.size() == 0 && !i_busy &&
          (!inc_d || (req_d_q.size() == 0 && !d_busy))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    tests_run++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_mem_resp, lsq_mem_resp,
         i_mem_rdata, lsq_mem_rdata, proto_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rd=%b wr=%b be=%h addr=%h wdata=%h iresp=%b dresp=%b irdata=%h drdata=%h perr=%b, required all 0",
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_mem_resp, lsq_mem_resp,
               i_mem_rdata, lsq_mem_rdata, proto_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_tie();
    bit ok;
    int oi = obs_i, od = obs_d;
    mem_lat = 3;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h1111_0000, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h64, 32'h0, 32'h2222_0000, 1'b0, 1'b1, 1'b1));
    req_d_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    req_i_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h64, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_quiet(60, 1'b1, ok);
    tests_run++;
    if (!ok || obs_i - oi !== 1 || obs_d - od !== 1) begin
      tests_failed++;
      $display("FAIL tie_done: done=%b i_resps=%0d d_resps=%0d, required 1 1 1", ok, obs_i - oi, obs_d - od);
    end
  endtask

  task automatic test_lone_fetch();
    bit ok;
    int oi = obs_i, od = obs_d;
    mem_lat = 3;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1));
    req_i_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_quiet(60, 1'b1, ok);
    tests_run++;
    if (!ok || obs_i - oi !== 1 || obs_d - od !== 0) begin
      tests_failed++;
      $display("FAIL lone_fetch_done: done=%b i_resps=%0d d_resps=%0d, required 1 1 0", ok, obs_i - oi, obs_d - od);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int oi = obs_i, od = obs_d;
    mem_lat = 3;
    for (int k = 0; k < 6; k++) begin
      bit own_d = (k % 2 == 0);
      logic [31:0] a = own_d ? 32'h300 + 32'(k * 4) : 32'h80 + 32'(k * 4);
      exp_q.push_back(mk(own_d, 1'b1, 1'b0, 4'hF, a, 32'h0, 32'hC0DE_0000 + 32'(k),
                         k == 0, k > 0, k == 5));
      if (own_d) req_d_q.push_back(mk(own_d, 1'b1, 1'b0, 4'hF, a, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
      else       req_i_q.push_back(mk(own_d, 1'b1, 1'b0, 4'hF, a, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    end
    wait_quiet(200, 1'b1, ok);
    tests_run++;
    if (!ok || obs_i - oi !== 3 || obs_d - od !== 3) begin
      tests_failed++;
      $display("FAIL contention_done: done=%b i_resps=%0d d_resps=%0d, required 1 3 3", ok, obs_i - oi, obs_d - od);
    end
  endtask

  task automatic test_lsq_write();
    bit ok;
    int od = obs_d;
    mem_lat = 4;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'b0011, 32'h100, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b1));
    req_d_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'b0011, 32'h100, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_quiet(60, 1'b1, ok);
    tests_run++;
    if (!ok || obs_d - od !== 1) begin
      tests_failed++;
      $display("FAIL lsq_write_done: done=%b d_resps=%0d, required 1 1", ok, obs_d - od);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int oi, od;
    mem_lat = 2;
    req_d_q.push_back(mk(1'b1, 1'b1, 1'b1, 4'hF, 32'h400, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    #2;
    tests_run++;
    if (proto_err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_no_grant: perr=%b rd=%b wr=%b, required 1 0 0", proto_err, mem_read, mem_write);
    end
    oi = obs_i; od = obs_d;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 32'h70, 32'h0, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b1));
    req_i_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 32'h70, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_quiet(60, 1'b0, ok);
    tests_run++;
    if (!ok || obs_i - oi !== 1 || obs_d - od !== 0) begin
      tests_failed++;
      $display("FAIL illegal_fetch_served: done=%b i_resps=%0d d_resps=%0d, required 1 1 0", ok, obs_i - oi, obs_d - od);
    end
    mem_auto = 1'b0;
    spur_resp = 1'b1;
    @(negedge clk);
    #2;
    tests_run++;
    if (i_mem_resp !== 1'b0 || lsq_mem_resp !== 1'b0 || i_mem_rdata !== 32'h0 || lsq_mem_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL idle_spurious_resp: i_resp=%b lsq_resp=%b i_rdata=%h lsq_rdata=%h, required 0 0 0 0",
               i_mem_resp, lsq_mem_resp, i_mem_rdata, lsq_mem_rdata);
    end
    spur_resp = 1'b0;
    @(negedge clk);
    #2;
    tests_run++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_spurious: rd=%b wr=%b, required 0 0", mem_read, mem_write);
    end
    d_abort = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    tests_run++;
    if (proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL proto_err_sticky: perr=%b, required 1", proto_err);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_reset_busy();
    bit ok = 1'b0;
    int oi, od;
    mem_lat = 50;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    req_i_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (mem_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL reset_busy_grant: mem_read=%b, required 1 within 20 cycles", mem_read);
    end
    @(posedge clk);
    #3;
    oi = obs_i;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, i_mem_resp, lsq_mem_resp,
         i_mem_rdata, lsq_mem_rdata, proto_err} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: rd=%b wr=%b be=%h addr=%h iresp=%b dresp=%b perr=%b, required all 0",
               mem_read, mem_write, mem_byte_enable, mem_address, i_mem_resp, lsq_mem_resp, proto_err);
    end
    exp_q.delete();
    req_i_q.delete();
    req_d_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    mem_lat = 2;
    od = obs_d;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 32'hFEED_0001, 1'b1, 1'b0, 1'b1));
    req_d_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    wait_quiet(60, 1'b1, ok);
    tests_run++;
    if (!ok || obs_d - od !== 1 || obs_i - oi !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_lsq: done=%b d_resps=%0d i_resps=%0d, required 1 1 0", ok, obs_d - od, obs_i - oi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_lone_fetch();
    test_contention();
    test_lsq_write();
    test_illegal();
    test_reset_busy();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
